// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with configurable wait
// states, an owned storage array and a preload port for loading memory
// before the processor starts.
//
// Handshake: the requester holds req (with we/addr/wdata) high while the
// responder is IDLE. The request is accepted at the first edge where the
// state is IDLE, req=1 and ld_en=0. While busy=1, all request and preload
// inputs are ignored. ready=1 for exactly one cycle marks completion; rdata
// is valid in that cycle for reads and is held until the next read. A req
// still high in the IDLE cycle that follows the ready cycle starts a new
// access.
module mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;

    // WAIT is entered with LATENCY-1 so the access lands exactly LATENCY
    // edges after acceptance; with LATENCY=0 WAIT is never used.
    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nx;
    logic [3:0] cnt, cnt_nx;

    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;

    // Access controls for this edge. In IDLE with LATENCY=0 the access uses
    // the live request inputs; otherwise it uses the captured copies.
    logic              capture;
    logic              access;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_we;
    logic [DATA_W-1:0] acc_wdata;

    logic              mem_wr;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] mem [DEPTH];

    // Next-state, wait counter and access decode.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        capture   = 1'b0;
        access    = 1'b0;
        acc_addr  = addr_q;
        acc_we    = we_q;
        acc_wdata = wdata_q;
        case (state)
            IDLE: begin
                // Preload has priority: a request alongside ld_en is dropped.
                if (req && !ld_en) begin
                    capture   = 1'b1;
                    acc_addr  = addr;
                    acc_we    = we;
                    acc_wdata = wdata;
                    if (LATENCY == 0) begin
                        access   = 1'b1;
                        state_nx = RESP;
                    end else begin
                        cnt_nx   = CNT_INIT;
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    access   = 1'b1;
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Storage write port select; reset blocks any commit at its edge.
    always_comb begin
        mem_wr    = 1'b0;
        mem_waddr = acc_addr;
        mem_wdata = acc_wdata;
        if (!rst) begin
            if (state == IDLE && ld_en) begin
                mem_wr    = 1'b1;
                mem_waddr = ld_addr;
                mem_wdata = ld_data;
            end else if (access && acc_we) begin
                mem_wr = 1'b1;
            end
        end
    end

    // State, counter, captured request and read data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rdata <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (capture) begin
                addr_q  <= addr;
                we_q    <= we;
                wdata_q <= wdata;
            end
            if (access && !acc_we) begin
                rdata <= mem[acc_addr];
            end
        end
    end

    // Backing storage; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign ready     = (state == RESP);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory responder for the multicycle processor's bus: it services one read or write at a time from the processor's memory port with a configurable number of wait states, then raises `ready` for exactly one cycle. It also owns the backing storage array and has a preload port so a bench or loader can fill program/data memory before `start`. It sits between the processor's datapath memory controls and the storage. It replaces an ideal zero-latency memory, so the controller's wait-on-`ready` path is exercised.

## Interface
- `ADDR_W`, 8: address width; depth is 2^ADDR_W words, so every address is in range.
- `DATA_W`, 8: word width; a 16-bit instruction is fetched as two words, left then right.
- `LATENCY`, 2: wait cycles between acceptance and response; legal range 0..15.

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: reset; synchronous and active-high.
- `req` input 1: request valid, level-sensitive; sampled only in IDLE.
- `we` input 1: 1 = write, 0 = read; captured with `req`.
- `addr` input ADDR_W: word address; captured with `req`.
- `wdata` input DATA_W: write data; captured with `req`.
- `ld_en` input 1: preload strobe; honoured only in IDLE.
- `ld_addr` input ADDR_W: preload address.
- `ld_data` input DATA_W: preload data.
- `rdata` output DATA_W: registered read data; valid while `ready` is 1, held afterwards.
- `ready` output 1: one-cycle completion pulse for both reads and writes.
- `busy` output 1: 1 whenever the state is not IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP. Internal registers: `addr_q`, `we_q`, `wdata_q`, and a 4-bit wait counter `cnt`.
- Reset values: state IDLE, `cnt`=0, `ready`=0, `busy`=0, `rdata`=0. Reset does not clear the memory array.
- IDLE, `ld_en`=1: write `mem[ld_addr]` = `ld_data`. Ignore `req` in that cycle; it is not accepted. Preload has priority.
- IDLE, `req`=1, `ld_en`=0: capture `addr`, `we`, `wdata`.
  - If LATENCY=0, go to RESP and perform the access at this edge.
  - Otherwise set `cnt`=LATENCY-1 and go to WAIT.
- WAIT, `cnt`≠0: decrement `cnt`.
- WAIT, `cnt`=0: go to RESP and perform the access at this edge.
  - Write: `mem[addr_q]` = `wdata_q`; `rdata` unchanged.
  - Read: `rdata` = `mem[addr_q]`.
- RESP: `ready`=1 for this single cycle, then return to IDLE unconditionally.
- Inputs `req`, `we`, `addr`, `wdata`, `ld_*` are ignored outside IDLE. Changes to them mid-transaction have no effect.
- `req` still high in the IDLE cycle after RESP is a new request (back-to-back allowed). The requester drops `req` in the cycle `ready` is seen if it wants only one access.
- `ready` and `busy` are decoded from registered state. There is no combinational path from any input to any output.

## Timing
- Acceptance edge E0: the edge where state is IDLE, `req`=1 and `ld_en`=0.
- The access is performed at edge E0+LATENCY.
- `ready`=1 during the cycle between edges E0+LATENCY and E0+LATENCY+1.
- Total latency is LATENCY+1 cycles from acceptance to the end of `ready`. With no back-to-back pipelining, throughput is one access per LATENCY+2 cycles.
- `busy`=1 from after E0 through the RESP cycle inclusive.
- Read-after-write to the same address, back-to-back, returns the newly written value.
- Preload write: takes effect at the edge it is sampled; readable by a request accepted at the next edge.
- Reset mid-transaction (WAIT or RESP): next state IDLE, `ready`=0.
  - If `rst` is high at the edge where a write would commit, the write is not performed. Reset wins over all other actions at that edge.
  - No partial response is produced after reset.

## Test plan
- Preload then read, LATENCY=2: `ld_en` writes 0x3C to addr 0x10; `req`=1, `we`=0, `addr`=0x10 accepted at E0 -> `ready`=1 only in the cycle after E0+2, `rdata`=0x3C, `busy` high for 3 cycles.
- Write then read back-to-back: write 0xA5 to 0x20, keep `req` high with `we`=0, `addr`=0x20 -> two `ready` pulses 4 cycles apart; second returns `rdata`=0xA5; `rdata` unchanged by the write.
- LATENCY=0 build: read of a preloaded word 0x7E -> `ready` in the cycle right after acceptance, `rdata`=0x7E, no WAIT state visited.
- Preload priority and gating: `ld_en`=1 and `req`=1 together in IDLE -> preload done, request not accepted (`busy` stays 0). `ld_en` pulsed during WAIT -> memory unchanged.
- Reset mid-write: write 0xFF to 0x05 (old value 0x11), assert `rst` at the commit edge -> `ready` never pulses, state IDLE, subsequent read of 0x05 returns 0x11.
- Input change during WAIT: change `addr` and `we` after acceptance -> response uses the captured values only.
